hrange_param: RTL and testbench



---
 rtl/hrange_pkg.sv | 27 ++
 rtl/hrange_step_cmp.sv | 40 ++++
 rtl/hrange_param.sv | 105 ++++++++++
 tb/tb_hrange_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hrange_pkg.sv
// Shared types and the overflow-aware adder used by the range generator.
package hrange_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Arithmetic is done at MAX_W+1 bits so that any WIDTH <= MAX_W sum is exact.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic                   ovf;
    logic signed [MAX_W:0]  sum;
  } sum_t;

  // ovf flags a sum that no longer fits a signed w-bit value.
  function automatic sum_t add_ovf(input logic signed [MAX_W:0] a,
                                   input logic signed [MAX_W:0] b,
                                   input logic [6:0]            w);
    sum_t r;
    r.sum = a + b;
    r.ovf = r.sum[w] ^ r.sum[w - 7'd1];
    return r;
  endfunction

endpackage

// File: rtl/hrange_step_cmp.sv
// Candidate value (x or x+step) plus the range continue test against limit.
module hrange_step_cmp
  import hrange_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit ADD   = 1'b1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf,
  output logic             cont
);

  logic signed [MAX_W:0] xe;
  logic signed [MAX_W:0] le;
  logic signed [MAX_W:0] cand;
  logic                  step_pos;

  assign xe       = {{(MAX_W + 1 - WIDTH){x[WIDTH-1]}}, x};
  assign le       = {{(MAX_W + 1 - WIDTH){limit[WIDTH-1]}}, limit};
  assign step_pos = $signed(step) > 0;

  generate
    if (ADD) begin : g_add
      sum_t s;
      assign s    = add_ovf(xe, {{(MAX_W + 1 - WIDTH){step[WIDTH-1]}}, step}, 7'(WIDTH));
      assign cand = s.sum;
      assign ovf  = s.ovf;
    end else begin : g_pass
      assign cand = xe;
      assign ovf  = 1'b0;
    end
  endgenerate

  assign nxt  = cand[WIDTH-1:0];
  assign cont = step_pos ? (cand < le) : (cand > le);

endmodule

// File: rtl/hrange_param.sv
// Python-style range(base, limit, step) generator behind a start/ready/valid/done handshake.
module hrange_param
  import hrange_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic             _error,
  output logic [WIDTH-1:0] _0,
  output logic [CNT_W-1:0] _1
);

  state_t           state_reg;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] step_reg;
  logic [WIDTH-1:0] val_reg;
  logic [CNT_W-1:0] idx_reg;
  logic             valid_reg;
  logic             done_reg;
  logic             error_reg;

  logic [WIDTH-1:0] start_val;
  logic             start_ovf;
  logic             start_cont;
  logic [WIDTH-1:0] run_nxt;
  logic             run_ovf;
  logic             run_cont;

  hrange_step_cmp #(.WIDTH(WIDTH), .ADD(1'b0)) u_start_cmp (
    .x     (base),
    .step  (step),
    .limit (limit),
    .nxt   (start_val),
    .ovf   (start_ovf),
    .cont  (start_cont)
  );

  hrange_step_cmp #(.WIDTH(WIDTH), .ADD(1'b1)) u_run_cmp (
    .x     (val_reg),
    .step  (step_reg),
    .limit (limit_reg),
    .nxt   (run_nxt),
    .ovf   (run_ovf),
    .cont  (run_cont)
  );

  // A start in the same cycle as reset still captures the new sequence.
  always_ff @(posedge _clock) begin
    done_reg <= 1'b0;
    if (_start) begin
      limit_reg <= limit;
      step_reg  <= step;
      idx_reg   <= '0;
      error_reg <= 1'b0;
      if (step == '0) begin
        error_reg <= 1'b1;
        done_reg  <= 1'b1;
        valid_reg <= 1'b0;
        state_reg <= IDLE;
      end else if (start_cont && !start_ovf) begin
        val_reg   <= start_val;
        valid_reg <= 1'b1;
        state_reg <= RUN;
      end else begin
        done_reg  <= 1'b1;
        valid_reg <= 1'b0;
        state_reg <= IDLE;
      end
    end else if (_reset) begin
      state_reg <= IDLE;
      limit_reg <= '0;
      step_reg  <= '0;
      val_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else if (state_reg == RUN && (_ready || !valid_reg)) begin
      if (run_ovf || !run_cont) begin
        done_reg  <= 1'b1;
        valid_reg <= 1'b0;
        state_reg <= IDLE;
      end else begin
        val_reg   <= run_nxt;
        idx_reg   <= idx_reg + CNT_W'(1);
        valid_reg <= 1'b1;
      end
    end
  end

  assign _valid = valid_reg;
  assign _done  = done_reg;
  assign _error = error_reg;
  assign _0     = val_reg;
  assign _1     = idx_reg;

endmodule

// File: tb/tb_hrange_param.sv
// Vector-table bench for hrange_param (32-bit and 8-bit instances) with a value scoreboard.
module tb_hrange_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [31:0] base32 = '0, limit32 = '0, step32 = '0;
  logic [7:0]  base8 = '0, limit8 = '0, step8 = '0;
  logic        v32, d32, e32, v8, d8, e8;
  logic [31:0] o32, i32, i8;
  logic [7:0]  o8;

  always #5 clk = ~clk;

  hrange_param #(.WIDTH(32), .CNT_W(32)) dut32 (
    ._clock(clk), ._reset(rst), ._start(start32), .base(base32), .limit(limit32),
    .step(step32), ._ready(ready), ._valid(v32), ._done(d32), ._error(e32), ._0(o32), ._1(i32));

  hrange_param #(.WIDTH(8), .CNT_W(32)) dut8 (
    ._clock(clk), ._reset(rst), ._start(start8), .base(base8), .limit(limit8),
    .step(step8), ._ready(ready), ._valid(v8), ._done(d8), ._error(e8), ._0(o8), ._1(i8));

  logic               sel = 1'b0;
  logic               m_valid, m_done, m_err;
  logic signed [31:0] m_val;
  logic [31:0]        m_idx;
  assign m_valid = sel ? v8 : v32;
  assign m_done  = sel ? d8 : d32;
  assign m_err   = sel ? e8 : e32;
  assign m_val   = sel ? {{24{o8[7]}}, o8} : o32;
  assign m_idx   = sel ? i8 : i32;

  typedef struct {
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    int                 n;
    bit                 err;
    bit                 w8;
    bit                 rst_ws;
    int                 stall_val;
    int                 stall_n;
  } vec_t;

  typedef struct {
    longint val;
    longint idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic build_model(input vec_t v);
    longint x, lim, st, lo, hi, idx;
    q.delete();
    x   = v.w8 ? longint'($signed(v.base[7:0]))  : longint'(v.base);
    lim = v.w8 ? longint'($signed(v.limit[7:0])) : longint'(v.limit);
    st  = v.w8 ? longint'($signed(v.step[7:0]))  : longint'(v.step);
    lo  = v.w8 ? -128 : -64'sd2147483648;
    hi  = v.w8 ? 127  : 64'sd2147483647;
    idx = 0;
    if (st != 0) begin
      while (x >= lo && x <= hi && ((st > 0) ? (x < lim) : (x > lim))) begin
        q.push_back('{val: x, idx: idx});
        x   = x + st;
        idx = idx + 1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit   finished = 0;
    bit   prev_ev;
    int   accepted = 0;
    int   stalls = 0;
    exp_t e;
    build_model(v);
    @(negedge clk);
    sel   = v.w8;
    ready = 1'b1;
    rst   = v.rst_ws;
    if (v.w8) begin
      base8 = v.base[7:0]; limit8 = v.limit[7:0]; step8 = v.step[7:0]; start8 = 1'b1;
    end else begin
      base32 = v.base; limit32 = v.limit; step32 = v.step; start32 = 1'b1;
    end
    $display("start base=%0d limit=%0d step=%0d w8=%0b expect %0d values", v.base, v.limit, v.step, v.w8, q.size());
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
    rst     = 1'b0;
    prev_ev = 1'b1;
    for (int c = 0; c < 64 && !finished; c++) begin
      check(m_valid || m_done, "no_gap", m_valid, 1);
      if (m_done) begin
        check(!m_valid, "done_with_valid", m_valid, 0);
        check(prev_ev, "done_timing", prev_ev, 1);
        check(accepted == v.n, "value_count", accepted, v.n);
        check(q.size() == 0, "leftover_values", q.size(), 0);
        check(m_err == v.err, "error_flag", m_err, v.err);
        $display("done after %0d values, error=%0b", accepted, m_err);
        finished = 1;
        ready    = 1'b1;
      end else if (m_valid) begin
        check(q.size() != 0, "extra_value", m_val, 0);
        if (q.size() != 0) begin
          if (v.stall_n > 0 && m_val == v.stall_val && stalls < v.stall_n) begin
            ready = 1'b0;
            stalls++;
            check(longint'(m_val) == q[0].val, "stall_hold_val", m_val, q[0].val);
            check(longint'(m_idx) == q[0].idx, "stall_hold_idx", m_idx, q[0].idx);
            $display("stall value=%0d index=%0d", m_val, m_idx);
            prev_ev = 1'b0;
          end else begin
            ready = 1'b1;
            e = q.pop_front();
            check(longint'(m_val) == e.val, "value", m_val, e.val);
            check(longint'(m_idx) == e.idx, "index", m_idx, e.idx);
            $display("value=%0d index=%0d", m_val, m_idx);
            accepted++;
            prev_ev = 1'b1;
          end
        end
      end
      if (!finished) @(negedge clk);
    end
    check(finished, "timeout", finished, 1);
    if (v.err) begin
      repeat (3) @(negedge clk);
      check(m_err == 1'b1, "error_hold", m_err, 1);
      check(m_done == 1'b0, "done_single_pulse", m_done, 0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    bit seen;
    vecs[0] = '{base: 0,  limit: 10, step: 2,  n: 5, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[1] = '{base: 10, limit: 0,  step: -3, n: 4, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[2] = '{base: 5,  limit: 5,  step: 1,  n: 0, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[3] = '{base: 0,  limit: 3,  step: 0,  n: 0, err: 1, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[4] = '{base: 0,  limit: 3,  step: 1,  n: 3, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[5] = '{base: 100, limit: 127, step: 20, n: 2, err: 0, w8: 1, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[6] = '{base: 0,  limit: 10, step: 2,  n: 5, err: 0, w8: 0, rst_ws: 0, stall_val: 4, stall_n: 3};
    vecs[7] = '{base: -5, limit: -20, step: -5, n: 3, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[8] = '{base: 32'sh7ffffffe, limit: 32'sh7fffffff, step: 2, n: 1, err: 0, w8: 0, rst_ws: 0, stall_val: 0, stall_n: 0};
    vecs[9] = '{base: 1,  limit: 3,  step: 1,  n: 2, err: 0, w8: 0, rst_ws: 1, stall_val: 0, stall_n: 0};

    repeat (3) @(negedge clk);
    check(v32 == 1'b0 && d32 == 1'b0 && e32 == 1'b0, "reset_flags32", {v32, d32, e32}, 0);
    check(o32 == '0 && i32 == '0, "reset_data32", o32, 0);
    check(v8 == 1'b0 && d8 == 1'b0 && e8 == 1'b0, "reset_flags8", {v8, d8, e8}, 0);
    check(o8 == '0 && i8 == '0, "reset_data8", o8, 0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // Reset while a sequence is streaming kills it without a done pulse.
    @(negedge clk);
    sel = 1'b0; ready = 1'b1;
    base32 = 0; limit32 = 10; step32 = 2; start32 = 1'b1;
    $display("start base=0 limit=10 step=2, reset after value 2");
    @(negedge clk);
    start32 = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (v32 && o32 == 32'd2) seen = 1;
      else @(negedge clk);
    end
    check(seen, "reach_value2", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check(v32 == 1'b0 && d32 == 1'b0, "midreset_flags", {v32, d32}, 0);
    check(o32 == '0 && i32 == '0, "midreset_data", o32, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check(v32 == 1'b0 && d32 == 1'b0, "midreset_quiet", {v32, d32}, 0);
    end
    $display("reset mid-stream, generator idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
